mem_bus_arbiter: RTL and testbench

- Two-master round-robin arbiter for the native valid/ready memory bus (valid, instr, addr, wdata, wstrb, ready, rdata).
- Shares one slave-side bus (ROM/RAM/UART/GPIO decode) between the CPU (m0) and a second master (m1, e.g. DMA or boot loader).
- Granularity is one full transaction; there is no mid-transfer preemption.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_wdt.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_TO_W = 16;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hBADB_0500;

    // Arbiter state doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mem_arb_wdt.sv
// Slave-response watchdog: counts stalled grant cycles and flags when the limit is reached.
module mem_arb_wdt
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic tick,
    output logic expired_c
);

    logic [ARB_TO_W-1:0] count;

    // Saturating counter so a stuck grant cannot wrap back below the limit.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count + ARB_TO_W'(1);
        end
    end

    assign expired_c = (count == ARB_TO_W'(LIMIT));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus.
// Define MEM_ARB_TIMEOUT_EN to add the slave-response watchdog (mem_arb_wdt).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  m0_valid,
    input  logic                  m0_instr,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_ready,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_valid,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_ready,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  s_valid,
    output logic                  s_instr,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_ready,
    input  logic [DATA_W-1:0]     s_rdata,

    output logic [1:0]            grant,
    output logic                  arb_timeout
);

    arb_state_e state;
    arb_state_e state_nxt;
    logic       last_m1;
    logic       last_m1_nxt;
    logic       to_expired_c;

    // Watchdog limit must be non-zero and fit the counter.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (TIMEOUT_CYCLES >= 1 && TIMEOUT_CYCLES < (1 << ARB_TO_W));
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (state == ARB_IDLE),
        .tick      ((state != ARB_IDLE) && !s_ready),
        .expired_c (to_expired_c)
    );
`else
    assign to_expired_c = 1'b0;
`endif

    // last_m1 resets high so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ARB_IDLE;
            last_m1 <= 1'b1;
        end else begin
            state   <= state_nxt;
            last_m1 <= last_m1_nxt;
        end
    end

    assign grant = state;

    always_comb begin
        state_nxt   = state;
        last_m1_nxt = last_m1;
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        arb_timeout = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_nxt = last_m1 ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_valid) begin
                    state_nxt = ARB_GNT0;
                end else if (m1_valid) begin
                    state_nxt = ARB_GNT1;
                end
            end

            ARB_GNT0: begin
                s_valid  = m0_valid;
                s_instr  = m0_instr;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready;
                m0_rdata = s_rdata;
                // A dropped valid abandons the grant without moving the round-robin pointer.
                if (!m0_valid) begin
                    state_nxt = ARB_IDLE;
                end else if (s_ready) begin
                    state_nxt   = ARB_IDLE;
                    last_m1_nxt = 1'b0;
                end else if (to_expired_c) begin
                    s_valid     = 1'b0;
                    m0_ready    = 1'b1;
                    m0_rdata    = DATA_W'(ARB_TIMEOUT_RDATA);
                    arb_timeout = 1'b1;
                    state_nxt   = ARB_IDLE;
                    last_m1_nxt = 1'b0;
                end
            end

            ARB_GNT1: begin
                s_valid  = m1_valid;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready;
                m1_rdata = s_rdata;
                if (!m1_valid) begin
                    state_nxt = ARB_IDLE;
                end else if (s_ready) begin
                    state_nxt   = ARB_IDLE;
                    last_m1_nxt = 1'b1;
                end else if (to_expired_c) begin
                    s_valid     = 1'b0;
                    m1_ready    = 1'b1;
                    m1_rdata    = DATA_W'(ARB_TIMEOUT_RDATA);
                    arb_timeout = 1'b1;
                    state_nxt   = ARB_IDLE;
                    last_m1_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a cycle-level ownership model.
// Timeout scenarios are compiled in only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    localparam int unsigned TO = 4;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m0_instr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [3:0]  m0_wstrb = '0;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_valid = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m1_wstrb = '0;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  grant;
    logic        arb_timeout;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .arb_timeout(arb_timeout)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus (-1 none, 0, 1), who was served last, stalled cycles.
    int own  = -1;
    int last = 1;
    int cnt  = 0;

    req_t        q0[$], q1[$];
    int unsigned m_prob = 0, s_prob = 100;
    bit          force_rdy = 1'b0, fix_en = 1'b0;
    logic [31:0] fix_rdata = '0;
    logic        rdy_s0 = 1'b0, rdy_s1 = 1'b0, sv_s = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.instr = 1'($urandom);
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.wstrb = 4'($urandom);
        return r;
    endfunction

    task automatic model_check();
        logic [1:0]  eg;
        logic        esv, einstr, er0, er1, eto;
        logic [31:0] ea, ed, er0d, er1d;
        logic [3:0]  es;
        eg = 2'b00; esv = 0; einstr = 0; ea = '0; ed = '0; es = '0;
        er0 = 0; er1 = 0; er0d = '0; er1d = '0; eto = 0;
        if (own == 0) begin
            eg = 2'b01; esv = m0_valid; einstr = m0_instr;
            ea = m0_addr; ed = m0_wdata; es = m0_wstrb;
            er0 = s_ready; er0d = s_rdata;
        end else if (own == 1) begin
            eg = 2'b10; esv = m1_valid;
            ea = m1_addr; ed = m1_wdata; es = m1_wstrb;
            er1 = s_ready; er1d = s_rdata;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        if (own >= 0 && esv && !s_ready && cnt == int'(TO)) begin
            esv = 0; eto = 1;
            if (own == 0) begin er0 = 1; er0d = 32'hBADB_0500; end
            else begin er1 = 1; er1d = 32'hBADB_0500; end
        end
`endif
        check_eq("grant", grant, eg);
        check_eq("s_valid", s_valid, esv);
        check_eq("s_instr", s_instr, einstr);
        check_eq("s_addr", s_addr, ea);
        check_eq("s_wdata", s_wdata, ed);
        check_eq("s_wstrb", s_wstrb, es);
        check_eq("m0_ready", m0_ready, er0);
        check_eq("m0_rdata", m0_rdata, er0d);
        check_eq("m1_ready", m1_ready, er1);
        check_eq("m1_rdata", m1_rdata, er1d);
        check_eq("arb_timeout", arb_timeout, eto);
    endtask

    // Applies one clock edge to the model using the inputs held during the finished cycle.
    task automatic model_update();
        logic vx;
        if (!resetn) begin
            own = -1; last = 1; cnt = 0;
        end else if (own < 0) begin
            cnt = 0;
            if (m0_valid && m1_valid) own = 1 - last;
            else if (m0_valid)        own = 0;
            else if (m1_valid)        own = 1;
        end else begin
            vx = (own == 0) ? m0_valid : m1_valid;
            if (!vx) begin
                own = -1;
            end else if (s_ready) begin
                last = own; own = -1;
`ifdef MEM_ARB_TIMEOUT_EN
            end else if (cnt == int'(TO)) begin
                last = own; own = -1;
`endif
            end else begin
                cnt++;
            end
        end
    endtask

    task automatic drive();
        req_t r;
        if (m0_valid && rdy_s0) m0_valid = 1'b0;
        if (!m0_valid && (q0.size() > 0 || ($urandom % 100) < m_prob)) begin
            r = (q0.size() > 0) ? q0.pop_front() : rand_req();
            m0_valid = 1'b1; m0_instr = r.instr; m0_addr = r.addr;
            m0_wdata = r.wdata; m0_wstrb = r.wstrb;
        end
        if (m1_valid && rdy_s1) m1_valid = 1'b0;
        if (!m1_valid && (q1.size() > 0 || ($urandom % 100) < m_prob)) begin
            r = (q1.size() > 0) ? q1.pop_front() : rand_req();
            m1_valid = 1'b1; m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb;
        end
        // Slave answers one or more cycles after it saw s_valid, never two cycles in a row.
        if (sv_s && !s_ready && (force_rdy || ($urandom % 100) < s_prob)) begin
            s_ready = 1'b1; force_rdy = 1'b0;
        end else begin
            s_ready = 1'b0;
        end
        s_rdata = fix_en ? fix_rdata : $urandom;
    endtask

    // One clock: model edge, drive after the edge, check and sample at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        drive();
        @(negedge clk);
        model_check();
        rdy_s0 = m0_ready; rdy_s1 = m1_ready; sv_s = s_valid;
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        m0_valid = 1'b0; m1_valid = 1'b0; m_prob = 0; force_rdy = 1'b0;
        resetn = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;
    endtask

    task automatic wait_grant(input logic [1:0] g, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle();
            if (grant == g) ok = 1'b1;
        end
    endtask

    initial begin
        bit          ok;
        int          gseq[$], gaps[$];
        int          idle;
        logic [1:0]  prevg;
        bit          seen;
        req_t        r;

        do_reset();
        check_eq("rst_grant", grant, 2'b00);
        check_eq("rst_s_valid", s_valid, 1'b0);
        check_eq("rst_arb_timeout", arb_timeout, 1'b0);

        // Single CPU read through a one-cycle slave.
        s_prob = 100; fix_en = 1'b1; fix_rdata = 32'h1234_5678;
        r = '0; r.addr = 32'h0000_0010;
        q0.push_back(r);
        cycle();
        check_eq("t1_c0_s_valid", s_valid, 1'b0);
        cycle();
        check_eq("t1_c1_s_valid", s_valid, 1'b1);
        check_eq("t1_c1_grant", grant, 2'b01);
        check_eq("t1_c1_addr", s_addr, 32'h0000_0010);
        cycle();
        check_eq("t1_c2_m0_ready", m0_ready, 1'b1);
        check_eq("t1_c2_m0_rdata", m0_rdata, 32'h1234_5678);
        cycle();
        check_eq("t1_c3_grant", grant, 2'b00);
        check_eq("t1_c3_s_valid", s_valid, 1'b0);

        // Both masters saturated: grants alternate with a single idle cycle between.
        do_reset();
        fix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
        end
        idle = 0; prevg = 2'b00;
        for (int c = 0; c < 60 && gseq.size() < 6; c++) begin
            cycle();
            if (grant != 2'b00 && prevg == 2'b00) begin
                gseq.push_back(int'(grant));
                gaps.push_back(idle);
            end
            if (grant == 2'b00) idle++;
            else idle = 0;
            prevg = grant;
        end
        check_eq("t2_grant_count", gseq.size(), 6);
        foreach (gseq[i]) begin
            check_eq($sformatf("t2_grant_%0d", i), gseq[i], (i % 2 == 0) ? 1 : 2);
            if (i > 0) check_eq($sformatf("t2_gap_%0d", i), gaps[i], 1);
        end

        // Second-master write passes straight through; CPU never sees ready.
        do_reset();
        r.instr = 1'b0; r.addr = 32'h0000_4000; r.wdata = 32'hAABB_CCDD; r.wstrb = 4'b0011;
        q1.push_back(r);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            check_eq("t3_m0_ready", m0_ready, 1'b0);
            if (grant == 2'b10 && !seen) begin
                seen = 1'b1;
                check_eq("t3_s_valid", s_valid, 1'b1);
                check_eq("t3_s_addr", s_addr, 32'h0000_4000);
                check_eq("t3_s_wdata", s_wdata, 32'hAABB_CCDD);
                check_eq("t3_s_wstrb", s_wstrb, 4'b0011);
                check_eq("t3_s_instr", s_instr, 1'b0);
            end
        end
        check_eq("t3_granted", seen, 1'b1);

        // Reset while m1 holds a stalled grant; afterwards the CPU wins the tie.
        do_reset();
        s_prob = 0;
        q1.push_back(rand_req());
        wait_grant(2'b10, ok);
        check_eq("t4_m1_granted", ok, 1'b1);
        resetn = 1'b0;
        cycle();
        check_eq("t4_rst_grant", grant, 2'b00);
        check_eq("t4_rst_s_valid", s_valid, 1'b0);
        check_eq("t4_rst_m1_ready", m1_ready, 1'b0);
        q0.push_back(rand_req());
        cycle();
        resetn = 1'b1;
        cycle();
        check_eq("t4_m0_first", grant, 2'b01);
        s_prob = 100;
        for (int c = 0; c < 20; c++) cycle();

`ifdef MEM_ARB_TIMEOUT_EN
        // Slave never answers: watchdog completes the CPU access.
        do_reset();
        s_prob = 0; fix_en = 1'b1; fix_rdata = 32'hCAFE_0001;
        q0.push_back(rand_req());
        wait_grant(2'b01, ok);
        check_eq("t5_granted", ok, 1'b1);
        for (int c = 1; c < int'(TO); c++) begin
            cycle();
            check_eq("t5_no_timeout_yet", arb_timeout, 1'b0);
        end
        cycle();
        check_eq("t5_timeout", arb_timeout, 1'b1);
        check_eq("t5_m0_ready", m0_ready, 1'b1);
        check_eq("t5_m0_rdata", m0_rdata, 32'hBADB_0500);
        check_eq("t5_s_valid", s_valid, 1'b0);
        cycle();
        check_eq("t5_idle", grant, 2'b00);

        // Slave answers exactly on the timeout cycle: the real response wins.
        do_reset();
        q0.push_back(rand_req());
        wait_grant(2'b01, ok);
        check_eq("t6_granted", ok, 1'b1);
        for (int c = 1; c < int'(TO); c++) cycle();
        force_rdy = 1'b1;
        cycle();
        check_eq("t6_m0_ready", m0_ready, 1'b1);
        check_eq("t6_m0_rdata", m0_rdata, 32'hCAFE_0001);
        check_eq("t6_no_timeout", arb_timeout, 1'b0);
        cycle();
        fix_en = 1'b0;
`endif

        // Random traffic, random slave latency and occasional resets.
        do_reset();
        fix_en = 1'b0; m_prob = 30; s_prob = 40;
        for (int c = 0; c < 800; c++) begin
            cycle();
            resetn = (($urandom % 100) != 0);
        end
        resetn = 1'b1; m_prob = 0; s_prob = 100;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            cycle();
            ok = !m0_valid && !m1_valid && (grant == 2'b00);
        end
        check_eq("drain", ok, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
